// File: rtl/kernel_frame_ctrl.sv
// Frame sequencer for the 3x3 kernel datapath: tracks the video position,
// qualifies window output and commits debounced effect modes at frame start.
module kernel_frame_ctrl #(
    parameter int LINE_WIDTH  = 1920,
    parameter int FRAME_LINES = 1080,
    parameter int CNT_W       = 12,
    parameter int STABLE_CYC  = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_vid_VDE,
    input  logic             i_vid_VSYNC,
    input  logic [3:0]       sw,
    output logic [3:0]       o_mode,
    output logic             o_win_valid,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic [1:0]       o_state,
    output logic             o_len_err,
    output logic             o_frame_done
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        PRIME      = 2'd1,
        RUN        = 2'd2
    } state_t;

    localparam int SC_W = $clog2(STABLE_CYC + 1);

    localparam logic [CNT_W-1:0] LW      = CNT_W'(LINE_WIDTH);
    localparam logic [CNT_W-1:0] LAST_Y  = CNT_W'(FRAME_LINES - 1);
    localparam logic [CNT_W-1:0] PRIME_Y = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] X_MAX   = {CNT_W{1'b1}};
    localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STABLE_CYC);

    state_t           state_q;
    state_t           state_d;
    logic             done_d;
    logic             vs_d;
    logic             vde_d;
    logic [CNT_W-1:0] x_cnt;
    logic [CNT_W-1:0] y_cnt;
    logic             frame_full;

    logic [3:0]       sw_m;
    logic [3:0]       sw_s;
    logic [3:0]       sw_s_d;
    logic [SC_W-1:0]  stab_cnt;
    logic [3:0]       pending;

    logic vs_rise;
    logic active;
    logic accept;
    logic eol;
    logic last_line;

    assign vs_rise   = i_vid_VSYNC & ~vs_d;
    assign active    = (state_q != WAIT_FRAME);
    assign accept    = active & i_vid_VDE & ~vs_rise;
    assign eol       = active & vde_d & ~i_vid_VDE & ~vs_rise;
    assign last_line = (y_cnt == LAST_Y);
    assign o_state   = state_q;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= WAIT_FRAME;
        else        state_q <= state_d;
    end

    // Frame phase sequencing; frame start overrides everything.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (vs_rise) begin
            state_d = PRIME;
        end else if (eol) begin
            if (last_line) begin
                state_d = WAIT_FRAME;
                done_d  = 1'b1;
            end else if (state_q == PRIME && y_cnt == PRIME_Y) begin
                state_d = RUN;
            end
        end
    end

    // Edge-detect history for VSYNC and VDE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vs_d  <= 1'b0;
            vde_d <= 1'b0;
        end else begin
            vs_d  <= i_vid_VSYNC;
            vde_d <= i_vid_VDE;
        end
    end

    // Pixel/line counters and the reported position of the last sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
            o_x   <= '0;
            o_y   <= '0;
        end else if (vs_rise) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (eol) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 1'b1;
        end else if (accept) begin
            o_x   <= x_cnt;
            o_y   <= y_cnt;
            x_cnt <= (x_cnt == X_MAX) ? x_cnt : x_cnt + 1'b1;
        end
    end

    // Window qualifier and frame-done pulse, aligned with the window shift.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_win_valid  <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_win_valid  <= accept && (x_cnt >= TWO) &&
                            (y_cnt >= TWO) && (state_q == RUN);
            o_frame_done <= done_d;
        end
    end

    // Sticky geometry error; a frame start mid-line counts as an error.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_len_err  <= 1'b0;
            frame_full <= 1'b0;
        end else if (vs_rise) begin
            o_len_err  <= i_vid_VDE;
            frame_full <= 1'b0;
        end else begin
            if (done_d)
                frame_full <= 1'b1;
            if ((eol && x_cnt != LW) ||
                (!active && i_vid_VDE && frame_full))
                o_len_err <= 1'b1;
        end
    end

    // Switch synchroniser and stability filter feeding the pending mode.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sw_m     <= '0;
            sw_s     <= '0;
            sw_s_d   <= '0;
            stab_cnt <= '0;
            pending  <= '0;
        end else begin
            sw_m   <= sw;
            sw_s   <= sw_m;
            sw_s_d <= sw_s;
            if (sw_s != sw_s_d)
                stab_cnt <= '0;
            else if (stab_cnt == SC_MAX)
                pending <= sw_s;
            else
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Effect mode changes only at frame start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)       o_mode <= '0;
        else if (vs_rise) o_mode <= pending;
    end

endmodule

// File: tb/tb_kernel_frame_ctrl.sv
// Directed bench for kernel_frame_ctrl with an 8x4 frame geometry.
// Each task drives one scenario and checks hand-computed expectations.
module tb_kernel_frame_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        vde = 1'b0;
    logic        vs = 1'b0;
    logic [3:0]  sw = 4'b0000;
    logic [3:0]  o_mode;
    logic        o_win_valid;
    logic [11:0] o_x;
    logic [11:0] o_y;
    logic [1:0]  o_state;
    logic        o_len_err;
    logic        o_frame_done;

    int checks = 0;
    int fails = 0;
    int win_cnt = 0;
    int fd_cnt = 0;
    bit tog = 1'b0;

    kernel_frame_ctrl #(
        .LINE_WIDTH(8),
        .FRAME_LINES(4),
        .CNT_W(12),
        .STABLE_CYC(4)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .i_vid_VDE(vde),
        .i_vid_VSYNC(vs),
        .sw(sw),
        .o_mode(o_mode),
        .o_win_valid(o_win_valid),
        .o_x(o_x),
        .o_y(o_y),
        .o_state(o_state),
        .o_len_err(o_len_err),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic s);
        vde = v;
        vs = s;
        @(posedge clk);
        #1;
        if (o_win_valid) win_cnt++;
        if (o_frame_done) fd_cnt++;
    endtask

    task automatic line(input int n, input int gap);
        repeat (n) cyc(1'b1, 1'b0);
        repeat (gap) cyc(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({o_mode, o_win_valid, o_x, o_y, o_state, o_len_err, o_frame_done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got mode=%h wv=%b x=%0d y=%0d st=%0d err=%b fd=%b want all 0",
                     o_mode, o_win_valid, o_x, o_y, o_state, o_len_err, o_frame_done);
        end
        @(posedge clk);
        @(posedge clk);
        #1 n_rst = 1'b1;
        line(8, 2);
        checks++;
        if (o_state !== 2'd0 || o_x !== 12'd0) begin
            fails++;
            $display("FAIL reset_idle: got st=%0d x=%0d want 0 0", o_state, o_x);
        end
    endtask

    task automatic test_frame();
        win_cnt = 0;
        fd_cnt = 0;
        cyc(1'b0, 1'b1);
        checks++;
        if (o_state !== 2'd1) begin
            fails++;
            $display("FAIL frame_prime: got st=%0d want 1", o_state);
        end
        cyc(1'b0, 1'b0);
        line(8, 2);
        checks++;
        if (o_state !== 2'd1) begin
            fails++;
            $display("FAIL frame_line0: got st=%0d want 1", o_state);
        end
        line(8, 2);
        checks++;
        if (o_state !== 2'd2) begin
            fails++;
            $display("FAIL frame_run: got st=%0d want 2", o_state);
        end
        line(8, 2);
        line(8, 2);
        checks++;
        if (win_cnt !== 12) begin
            fails++;
            $display("FAIL frame_win_cnt: got %0d want 12", win_cnt);
        end
        checks++;
        if (fd_cnt !== 1) begin
            fails++;
            $display("FAIL frame_done_cnt: got %0d want 1", fd_cnt);
        end
        checks++;
        if (o_state !== 2'd0 || o_len_err !== 1'b0) begin
            fails++;
            $display("FAIL frame_end: got st=%0d err=%b want 0 0", o_state, o_len_err);
        end
        checks++;
        if (o_x !== 12'd7 || o_y !== 12'd3) begin
            fails++;
            $display("FAIL frame_last_pos: got x=%0d y=%0d want 7 3", o_x, o_y);
        end
    endtask

    task automatic test_mode_commit();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        line(8, 2);
        sw = 4'b0011;
        line(8, 2);
        line(8, 2);
        line(8, 2);
        checks++;
        if (o_mode !== 4'b0000) begin
            fails++;
            $display("FAIL mode_hold_midframe: got %b want 0000", o_mode);
        end
        cyc(1'b0, 1'b1);
        checks++;
        if (o_mode !== 4'b0011) begin
            fails++;
            $display("FAIL mode_commit: got %b want 0011", o_mode);
        end
        cyc(1'b0, 1'b0);
        repeat (4) line(8, 2);
    endtask

    task automatic test_sw_bounce();
        tog = 1'b1;
        fork
            begin
                while (tog) begin
                    sw = (sw == 4'b0101) ? 4'b0111 : 4'b0101;
                    repeat (3) @(posedge clk);
                    #1;
                end
                sw = 4'b0011;
            end
            begin
                for (int f = 0; f < 2; f++) begin
                    cyc(1'b0, 1'b1);
                    checks++;
                    if (o_mode !== 4'b0011) begin
                        fails++;
                        $display("FAIL bounce_mode_f%0d: got %b want 0011", f, o_mode);
                    end
                    cyc(1'b0, 1'b0);
                    repeat (4) line(8, 2);
                end
                cyc(1'b0, 1'b1);
                checks++;
                if (o_mode !== 4'b0011) begin
                    fails++;
                    $display("FAIL bounce_mode_f2: got %b want 0011", o_mode);
                end
                tog = 1'b0;
            end
        join
        cyc(1'b0, 1'b0);
        repeat (4) line(8, 2);
    endtask

    task automatic test_short_line();
        fd_cnt = 0;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        line(8, 2);
        checks++;
        if (o_len_err !== 1'b0) begin
            fails++;
            $display("FAIL short_before: got %b want 0", o_len_err);
        end
        line(7, 2);
        checks++;
        if (o_len_err !== 1'b1) begin
            fails++;
            $display("FAIL short_set: got %b want 1", o_len_err);
        end
        line(8, 2);
        line(8, 2);
        checks++;
        if (o_len_err !== 1'b1 || fd_cnt !== 1) begin
            fails++;
            $display("FAIL short_hold: got err=%b fd=%0d want 1 1", o_len_err, fd_cnt);
        end
        cyc(1'b0, 1'b1);
        checks++;
        if (o_len_err !== 1'b0 || o_state !== 2'd1) begin
            fails++;
            $display("FAIL short_clear: got err=%b st=%0d want 0 1", o_len_err, o_state);
        end
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_vsync_mid_line();
        line(8, 2);
        line(8, 2);
        repeat (4) cyc(1'b1, 1'b0);
        checks++;
        if (o_x !== 12'd3 || o_y !== 12'd2 || o_state !== 2'd2) begin
            fails++;
            $display("FAIL midvs_pre: got x=%0d y=%0d st=%0d want 3 2 2", o_x, o_y, o_state);
        end
        cyc(1'b1, 1'b1);
        checks++;
        if (o_state !== 2'd1 || o_len_err !== 1'b1) begin
            fails++;
            $display("FAIL midvs_restart: got st=%0d err=%b want 1 1", o_state, o_len_err);
        end
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        checks++;
        if (o_x !== 12'd1 || o_y !== 12'd0) begin
            fails++;
            $display("FAIL midvs_count: got x=%0d y=%0d want 1 0", o_x, o_y);
        end
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        checks++;
        if (o_len_err !== 1'b1) begin
            fails++;
            $display("FAIL midvs_err_hold: got %b want 1", o_len_err);
        end
    endtask

    task automatic test_reset_mid_frame();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        line(8, 2);
        line(8, 2);
        repeat (6) cyc(1'b1, 1'b0);
        checks++;
        if (o_x !== 12'd5 || o_y !== 12'd2 || o_win_valid !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre: got x=%0d y=%0d wv=%b want 5 2 1", o_x, o_y, o_win_valid);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({o_mode, o_win_valid, o_x, o_y, o_state, o_len_err, o_frame_done} !== '0) begin
            fails++;
            $display("FAIL rstmid_outputs: got mode=%h wv=%b x=%0d y=%0d st=%0d err=%b fd=%b want all 0",
                     o_mode, o_win_valid, o_x, o_y, o_state, o_len_err, o_frame_done);
        end
        repeat (2) cyc(1'b1, 1'b0);
        n_rst = 1'b1;
        win_cnt = 0;
        line(8, 3);
        checks++;
        if (o_state !== 2'd0 || o_x !== 12'd0 || o_y !== 12'd0 ||
            win_cnt !== 0 || o_len_err !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_ignore: got st=%0d x=%0d y=%0d wv=%0d err=%b want 0 0 0 0 0",
                     o_state, o_x, o_y, win_cnt, o_len_err);
        end
        cyc(1'b0, 1'b1);
        checks++;
        if (o_state !== 2'd1 || o_mode !== 4'b0011) begin
            fails++;
            $display("FAIL rstmid_restart: got st=%0d mode=%b want 1 0011", o_state, o_mode);
        end
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_mode_commit();
        test_sw_bounce();
        test_short_line();
        test_vsync_mid_line();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
